// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// The defaults describe 640x480@60 with a 25.175 MHz pixel step.
package vga_timing_gen_pkg;

    // Coordinate width shared by x_ord/y_ord and the range it can address
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned COORD_LIMIT = 1 << COORD_W;

    // Horizontal timing defaults (pixels)
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BACK_DEF   = 48;

    // Vertical timing defaults (lines)
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BACK_DEF   = 33;

    // Derived totals for the default mode (800 x 525)
    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Sync polarity encodings: value is the asserted level
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Pin sync delay and frame counter defaults
    localparam int unsigned SYNC_DELAY_DEF  = 2;
    localparam int unsigned SYNC_DELAY_MAX  = 7;
    localparam int unsigned FRAME_CNT_W_DEF = 16;

    typedef logic [COORD_W-1:0] coordT;

    // Raster position payload
    typedef struct packed {
        coordT x;
        coordT y;
    } rasterPosT;

    // Sum of the four segments of one timing axis
    function automatic int unsigned sumTiming(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Shift register that delays a sync level by DEPTH pixel steps.
// Stages advance only when shiftEn is high; DEPTH=0 is a straight wire.
module vga_timing_gen_sync_delay_line
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned DEPTH       = SYNC_DELAY_DEF,
    parameter bit          RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shiftEn,
    input  logic din,
    output logic dout
);

    if (DEPTH > SYNC_DELAY_MAX) begin : gBadDepth
        $error("sync delay depth out of range");
    end

    if (DEPTH == 0) begin : gBypass
        logic unusedBypass;
        assign unusedBypass = &{1'b0, clk, rst_n, shiftEn};
        assign dout = din;
    end else begin : gShift
        logic [DEPTH-1:0] stages;

        // Shift the sync level one stage per pixel step; hold otherwise
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stages <= {DEPTH{RESET_LEVEL}};
            end else if (shiftEn) begin
                stages <= DEPTH'({stages, din});
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, visible flag, sync pulses,
// line/frame start strobes and a frame counter, stepping on pix_en.
// Pin syncs are delayed to line up with the downstream RGB pipeline.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT     = H_FRONT_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BACK      = H_BACK_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT     = V_FRONT_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BACK      = V_BACK_DEF,
    parameter bit          HSYNC_POL   = SYNC_ACTIVE_LOW,
    parameter bit          VSYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int unsigned SYNC_DELAY  = SYNC_DELAY_DEF,
    parameter int unsigned FRAME_CNT_W = FRAME_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_en,
    output logic [COORD_W-1:0]     x_ord,
    output logic [COORD_W-1:0]     y_ord,
    output logic                   visible,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL  = sumTiming(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL  = sumTiming(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    // One extra bit so boundaries equal to COORD_LIMIT compare correctly
    localparam int unsigned CMP_W    = COORD_W + 1;

    localparam coordT X_LAST = COORD_W'(H_TOTAL - 1);
    localparam coordT Y_LAST = COORD_W'(V_TOTAL - 1);

    if (H_TOTAL == 0 || H_TOTAL > COORD_LIMIT) begin : gBadHTotal
        $error("horizontal total outside coordinate range");
    end
    if (V_TOTAL == 0 || V_TOTAL > COORD_LIMIT) begin : gBadVTotal
        $error("vertical total outside coordinate range");
    end
    if (SYNC_DELAY > SYNC_DELAY_MAX) begin : gBadSyncDelay
        $error("sync delay out of range");
    end

    rasterPosT posNext;
    logic      visibleNext;
    logic      inHsync;
    logic      inVsync;
    logic      hsyncRawNext;
    logic      vsyncRawNext;
    logic      lineStartNext;
    logic      frameStartNext;
    logic      hsyncRaw;
    logic      vsyncRaw;

    // Next raster position and the flags derived from it
    always_comb begin
        posNext        = '{x: x_ord, y: y_ord};
        visibleNext    = 1'b0;
        inHsync        = 1'b0;
        inVsync        = 1'b0;
        hsyncRawNext   = ~HSYNC_POL;
        vsyncRawNext   = ~VSYNC_POL;
        lineStartNext  = 1'b0;
        frameStartNext = 1'b0;

        if (x_ord == X_LAST) begin
            posNext.x = '0;
            if (y_ord == Y_LAST) begin
                posNext.y = '0;
            end else begin
                posNext.y = y_ord + COORD_W'(1);
            end
        end else begin
            posNext.x = x_ord + COORD_W'(1);
        end

        visibleNext = ({1'b0, posNext.x} < CMP_W'(H_ACTIVE)) &&
                      ({1'b0, posNext.y} < CMP_W'(V_ACTIVE));
        inHsync     = ({1'b0, posNext.x} >= CMP_W'(HS_START)) &&
                      ({1'b0, posNext.x} <  CMP_W'(HS_END));
        inVsync     = ({1'b0, posNext.y} >= CMP_W'(VS_START)) &&
                      ({1'b0, posNext.y} <  CMP_W'(VS_END));

        hsyncRawNext = inHsync ? HSYNC_POL : ~HSYNC_POL;
        vsyncRawNext = inVsync ? VSYNC_POL : ~VSYNC_POL;

        // Strobes only fire on a real step, so they drop on any idle edge
        lineStartNext  = pix_en && (posNext.x == '0);
        frameStartNext = lineStartNext && (posNext.y == '0);
    end

    // Raster state; reset parks the position on the last pixel of a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ord       <= X_LAST;
            y_ord       <= Y_LAST;
            visible     <= 1'b0;
            hsyncRaw    <= ~HSYNC_POL;
            vsyncRaw    <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= lineStartNext;
            frame_start <= frameStartNext;
            if (pix_en) begin
                x_ord    <= posNext.x;
                y_ord    <= posNext.y;
                visible  <= visibleNext;
                hsyncRaw <= hsyncRawNext;
                vsyncRaw <= vsyncRawNext;
                if (frameStartNext) begin
                    frame_count <= frame_count + FRAME_CNT_W'(1);
                end
            end
        end
    end

    vga_timing_gen_sync_delay_line #(
        .DEPTH       (SYNC_DELAY),
        .RESET_LEVEL (~HSYNC_POL)
    ) uHsyncDelay (
        .clk     (clk),
        .rst_n   (rst_n),
        .shiftEn (pix_en),
        .din     (hsyncRaw),
        .dout    (hsync)
    );

    vga_timing_gen_sync_delay_line #(
        .DEPTH       (SYNC_DELAY),
        .RESET_LEVEL (~VSYNC_POL)
    ) uVsyncDelay (
        .clk     (clk),
        .rst_n   (rst_n),
        .shiftEn (pix_en),
        .din     (vsyncRaw),
        .dout    (vsync)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default mode, default mode with
// a short vertical so frames fit the run, and a tiny active-high mode) share
// clock, reset and pix_en. A step-index model predicts every output each cycle.
module tb_vga_timing_gen;

    typedef struct {
        int hA, hF, hS, hB, vA, vF, vS, vB, hPol, vPol, dly, fcW;
    } modeT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vis;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } outT;

    typedef struct {
        int s; int x; int y; bit vis; bit hs; bit ls; bit fs; int fc;
    } vecT;

    logic clk    = 1'b0;
    bit   clkRun = 1'b0;
    logic rst_n  = 1'b1;
    logic pix_en = 1'b0;

    logic [9:0]  dX, dY, mX, mY, sX, sY;
    logic        dVis, dHs, dVs, dLs, dFs;
    logic        mVis, mHs, mVs, mLs, mFs;
    logic        sVis, sHs, sVs, sLs, sFs;
    logic [15:0] dFc, mFc;
    logic [3:0]  sFc;

    int   checks = 0;
    int   errors = 0;
    int   s = 0;
    bit   stepped = 1'b0;
    int   phase = 0;
    outT  expQ[$];
    vecT  tbl[11];
    int   tIdx = 0;
    int   hsLowD = 0;
    int   vsLowM = 0;
    int   vsFirstM = 0;
    int   fsSeenM = 0;
    int   fsPrevM = 0;
    modeT mD, mM, mS;

    always begin
        #5;
        if (clkRun) clk = ~clk;
    end

    vga_timing_gen uDutD (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x_ord(dX), .y_ord(dY), .visible(dVis), .hsync(dHs), .vsync(dVs),
        .line_start(dLs), .frame_start(dFs), .frame_count(dFc)
    );

    vga_timing_gen #(
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) uDutM (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x_ord(mX), .y_ord(mY), .visible(mVis), .hsync(mHs), .vsync(mVs),
        .line_start(mLs), .frame_start(mFs), .frame_count(mFc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .FRAME_CNT_W(4), .SYNC_DELAY(0)
    ) uDutS (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x_ord(sX), .y_ord(sY), .visible(sVis), .hsync(sHs), .vsync(sVs),
        .line_start(sLs), .frame_start(sFs), .frame_count(sFc)
    );

    // Expected outputs after sn steps since reset; st = last edge was a step
    function automatic outT expectOut(input modeT m, input int sn, input bit st);
        outT e;
        int  hT, vT, fT, p, x, y, k, pk, xk, yk;
        bit  hAct, vAct;
        hT = m.hA + m.hF + m.hS + m.hB;
        vT = m.vA + m.vF + m.vS + m.vB;
        fT = hT * vT;
        e = '0;
        if (sn == 0) begin
            e.x  = 10'(hT - 1);
            e.y  = 10'(vT - 1);
            e.hs = (m.hPol == 0);
            e.vs = (m.vPol == 0);
            return e;
        end
        p = (sn - 1) % fT;
        x = p % hT;
        y = p / hT;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.vis = (x < m.hA) && (y < m.vA);
        hAct = 1'b0;
        vAct = 1'b0;
        k = sn - m.dly;
        if (k >= 1) begin
            pk = (k - 1) % fT;
            xk = pk % hT;
            yk = pk / hT;
            hAct = (xk >= m.hA + m.hF) && (xk < m.hA + m.hF + m.hS);
            vAct = (yk >= m.vA + m.vF) && (yk < m.vA + m.vF + m.vS);
        end
        e.hs = hAct ? (m.hPol != 0) : (m.hPol == 0);
        e.vs = vAct ? (m.vPol != 0) : (m.vPol == 0);
        e.ls = st && (x == 0);
        e.fs = st && (p == 0);
        e.fc = 16'(((sn - 1) / fT + 1) % (1 << m.fcW));
        return e;
    endfunction

    function automatic outT actD();
        outT a;
        a.x = dX; a.y = dY; a.vis = dVis; a.hs = dHs; a.vs = dVs;
        a.ls = dLs; a.fs = dFs; a.fc = dFc;
        return a;
    endfunction

    function automatic outT actM();
        outT a;
        a.x = mX; a.y = mY; a.vis = mVis; a.hs = mHs; a.vs = mVs;
        a.ls = mLs; a.fs = mFs; a.fc = mFc;
        return a;
    endfunction

    function automatic outT actS();
        outT a;
        a.x = sX; a.y = sY; a.vis = sVis; a.hs = sHs; a.vs = sVs;
        a.ls = sLs; a.fs = sFs; a.fc = 16'(sFc);
        return a;
    endfunction

    task automatic checkOut(input string name, input outT act, input outT exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got x=%0d y=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     name, s, act.x, act.y, act.vis, act.hs, act.vs, act.ls, act.fs, act.fc,
                     exp.x, exp.y, exp.vis, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step=%0d got %0d want %0d", name, s, act, exp);
        end
    endtask

    task automatic pushExpected();
        expQ.push_back(expectOut(mD, s, stepped));
        expQ.push_back(expectOut(mM, s, stepped));
        expQ.push_back(expectOut(mS, s, stepped));
    endtask

    task automatic popCompare(input string tag);
        outT e;
        checkInt({tag, "_queue_depth"}, expQ.size(), 3);
        if (expQ.size() >= 3) begin
            e = expQ.pop_front(); checkOut({tag, "_default"}, actD(), e);
            e = expQ.pop_front(); checkOut({tag, "_shortv"},  actM(), e);
            e = expQ.pop_front(); checkOut({tag, "_small"},   actS(), e);
        end
        expQ.delete();
    endtask

    // Reset values must appear with no clock edge
    task automatic resetCheck(input string tag);
        s = 0;
        stepped = 1'b0;
        pushExpected();
        popCompare(tag);
    endtask

    // One clock cycle with the given pix_en; checks all instances after the edge
    task automatic step(input bit pe);
        outT e;
        pix_en = pe;
        if (pe) s++;
        stepped = pe;
        pushExpected();
        @(posedge clk);
        #1;
        popCompare("cycle");

        if (phase == 1) begin
            if (pe && s <= 800 && dHs == 1'b0) hsLowD++;
            if (pe && tIdx < 11 && s == tbl[tIdx].s) begin
                e = '0;
                e.x = 10'(tbl[tIdx].x); e.y = 10'(tbl[tIdx].y);
                e.vis = tbl[tIdx].vis; e.hs = tbl[tIdx].hs; e.vs = 1'b1;
                e.ls = tbl[tIdx].ls; e.fs = tbl[tIdx].fs; e.fc = 16'(tbl[tIdx].fc);
                checkOut($sformatf("table_%0d", tIdx), actD(), e);
                tIdx++;
            end
        end

        if (phase == 2) begin
            if (pe && s == 1) begin
                checkInt("restart_x", int'(dX), 0);
                checkInt("restart_y", int'(dY), 0);
                checkInt("restart_frame_count", int'(dFc), 1);
            end
            if (pe && s <= 15200 && mVs == 1'b0) begin
                vsLowM++;
                if (vsFirstM == 0) vsFirstM = s;
            end
            if (mFs == 1'b1) begin
                fsSeenM++;
                if (fsSeenM > 1) checkInt("frame_spacing", s - fsPrevM, 15200);
                fsPrevM = s;
            end
            if (pe && s == 1470) checkInt("small_fc_before_wrap", int'(sFc), 15);
            if (pe && s == 1471) checkInt("small_fc_wrap", int'(sFc), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at step %0d", s);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        mD = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 16};
        mM = '{640, 16, 96, 48, 12, 2, 2, 3, 0, 0, 2, 16};
        mS = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 0, 4};

        //          s     x    y  vis hs ls fs fc
        tbl[0]  = '{1,    0,   0,  1, 1, 1, 1, 1};
        tbl[1]  = '{640,  639, 0,  1, 1, 0, 0, 1};
        tbl[2]  = '{641,  640, 0,  0, 1, 0, 0, 1};
        tbl[3]  = '{657,  656, 0,  0, 1, 0, 0, 1};
        tbl[4]  = '{659,  658, 0,  0, 0, 0, 0, 1};
        tbl[5]  = '{754,  753, 0,  0, 0, 0, 0, 1};
        tbl[6]  = '{755,  754, 0,  0, 1, 0, 0, 1};
        tbl[7]  = '{800,  799, 0,  0, 1, 0, 0, 1};
        tbl[8]  = '{801,  0,   1,  1, 1, 1, 0, 1};
        tbl[9]  = '{1601, 0,   2,  1, 1, 1, 0, 1};
        tbl[10] = '{8301, 300, 10, 1, 1, 0, 0, 1};

        // Power-on reset with the clock stopped
        #2 rst_n = 1'b0;
        #3;
        resetCheck("power_on_reset");
        #20 rst_n = 1'b1;
        #5 clkRun = 1'b1;

        // Full-rate stepping with a half-rate window between steps 1000 and 3000
        phase = 1;
        cyc = 0;
        while (s < 8301) begin
            step((s >= 1000 && s < 3000) ? (cyc % 2 == 1) : 1'b1);
            cyc++;
        end
        checkInt("table_rows_hit", tIdx, 11);
        checkInt("hsync_low_steps_line0", hsLowD, 96);

        // Asynchronous reset mid-frame with no clock edge during the pulse
        clkRun = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        resetCheck("async_reset");
        #10 rst_n = 1'b1;
        #3 clkRun = 1'b1;

        // Two full short-vertical frames after the restart
        phase = 2;
        repeat (31000) step(1'b1);
        checkInt("vsync_low_steps", vsLowM, 1600);
        checkInt("vsync_first_low_step", vsFirstM, 14 * 800 + 1 + 2);
        checkInt("frame_start_pulses", fsSeenM, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream raster stage for the text/timer display core. Generates pixel coordinates, the visible flag and the horizontal/vertical sync pulses for a parameterised VGA mode, advancing on a pixel-enable strobe. Its outputs feed the display core's xOrd/yOrd/visible inputs. The hsync/vsync outputs go to the pins, delayed so that they line up with the core's RGB pipeline latency.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
SYNC_DELAY, 2, pixel steps of extra hsync/vsync delay, legal range 0..7
FRAME_CNT_W, 16, frame counter width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pix_en  input  1  pixel step strobe; the raster advances only on clk edges where pix_en=1
x_ord  output  10  horizontal position, 0..H_TOTAL-1
y_ord  output  10  vertical position, 0..V_TOTAL-1
visible  output  1  high when x_ord<H_ACTIVE and y_ord<V_ACTIVE
hsync  output  1  horizontal sync, delayed by SYNC_DELAY steps
vsync  output  1  vertical sync, delayed by SYNC_DELAY steps
line_start  output  1  one-clk pulse when the raster enters x_ord=0
frame_start  output  1  one-clk pulse when the raster enters (0,0)
frame_count  output  FRAME_CNT_W  frames started since reset, wraps modulo 2^FRAME_CNT_W

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800 at defaults); V_TOTAL = sum of the four V parameters (525). Both must be ≤1024; elaboration fails otherwise, and also if SYNC_DELAY>7.
- Reset (async, takes effect immediately without a clock edge): x_ord=H_TOTAL-1, y_ord=V_TOTAL-1, visible=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, frame_count=0, delay-line stages all at the inactive sync level.
- Every output is a register; no combinational path from inputs to outputs.
- On a clk edge with pix_en=1:
  - x_ord increments; if x_ord was H_TOTAL-1 it wraps to 0.
  - On that x wrap, y_ord increments; if y_ord was V_TOTAL-1 it wraps to 0.
  - visible, raw hsync and raw vsync are computed from the new position, so they stay aligned with x_ord/y_ord.
- Raw hsync is asserted for H_ACTIVE+H_FRONT ≤ x < H_ACTIVE+H_FRONT+H_SYNC (656..751 at defaults).
- Raw vsync is asserted for whole lines V_ACTIVE+V_FRONT ≤ y < V_ACTIVE+V_FRONT+V_SYNC (490..491 at defaults).
- Sync delay:
  - hsync/vsync pass through a SYNC_DELAY-deep shift register that advances only on pix_en edges.
  - Output at step n equals the raw value at step n-SYNC_DELAY.
  - SYNC_DELAY=0 means the outputs equal the raw values.
- line_start: asserted for the clk cycle following the edge that moved x_ord to 0.
- frame_start: asserted for the clk cycle following the edge that moved the position to (0,0).
- frame_count increments on that same edge. The first step after reset therefore yields position (0,0), frame_start=1, frame_count=1.
- Pulses are exactly one clk wide even when pix_en is held high; they deassert on any edge where pix_en=0.
- pix_en=0: position, visible, syncs, delay line and frame_count all hold.
- Reset mid-frame abandons the current frame. The raster restarts with the first pix_en step at (0,0); no partial-line recovery.

Decomposition:
- Shared package: default timing constants for 640x480@60, derived H_TOTAL/V_TOTAL, polarity constants, coordinate width (10).
- One sub-module: sync_delay_line.
  - Parameterised depth (0..7) and reset level, with shift enable.
  - Instantiated twice, for hsync and vsync.

Test Plan:
- Reset check: assert rst_n=0 with no clock running → outputs at reset values immediately (x=799, y=524, hsync=vsync=1). Release, hold pix_en=1 → first edge gives x=0, y=0, visible=1, frame_start and line_start high for 1 clk, frame_count=1.
- Horizontal timing, defaults: visible falls at x=640; raw hsync low for x=656..751 (96 steps). With SYNC_DELAY=2, the pin hsync is low while x=658..753. line_start fires every 800 steps.
- Vertical timing, defaults: 420000 pix_en steps between frame_start pulses; vsync low for exactly 1600 steps, delayed 2 steps relative to y=490 x=0; visible stays 0 for y≥480; frame_count 1→2.
- pix_en toggled every other clk: position advances at half rate; all state holds on low cycles; line_start/frame_start remain one clk wide.
- Async reset pulse while x=300, y=100, with no clk edge during the pulse → outputs go to reset values at once; after release, raster resumes at (0,0) with frame_count=1.
- Small mode (H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1, FRAME_CNT_W=4, SYNC_DELAY=0): hsync high at x=10..11; 98 steps per frame; after 16 frames frame_count wraps 15→0.
